imem_boot_loader: RTL and testbench

- Upstream of instruction memory. Receives a program as a byte stream over a valid/ready handshake and packs it into 32-bit little-endian instruction words.
- Writes each word to instruction memory through a single-cycle write port.
- Holds the processor core in reset until a complete, checksum-verified image is loaded.

---
 rtl/imem_boot_loader_if.sv | 30 +++
 rtl/imem_boot_loader.sv | 185 ++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// Byte-stream handshake plus instruction-memory write port used by the boot loader.
// The master drives the byte stream; the slave is the loader, which also drives the memory write port.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, XOR-checksummed byte image into instruction memory as
// little-endian 32-bit words and holds the core in reset until the image verifies.
module imem_boot_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  imem_boot_loader_if.slave    bus,
  output logic                 core_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [15:0]          words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  function automatic logic is_active(input state_t s);
    return (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_DATA) || (s == S_CHECK);
  endfunction

  state_t            state_r;
  state_t            state_nx_s;
  logic              start_acc_s;
  logic              xfer_s;
  logic [15:0]       len_nx_s;
  logic              last_word_s;
  logic [7:0]        chk_nx_s;

  logic [15:0]       len_r;
  logic [7:0]        chk_r;
  logic [1:0]        byte_idx_r;
  logic [31:0]       word_r;
  logic              in_ready_r;
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [31:0]       wr_data_r;
  logic              core_rst_r;
  logic              busy_r;
  logic              done_r;
  logic              error_r;
  logic [15:0]       words_loaded_r;

  assign xfer_s      = bus.in_valid && in_ready_r;
  assign len_nx_s    = {bus.in_data, len_r[7:0]};
  assign last_word_s = (words_loaded_r == (len_r - 16'd1));
  assign chk_nx_s    = chk_update(chk_r, bus.in_data);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode; start is only honoured outside an active load.
  always_comb begin
    state_nx_s  = state_r;
    start_acc_s = 1'b0;
    case (state_r)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_nx_s  = S_LEN_LO;
          start_acc_s = 1'b1;
        end else begin
          state_nx_s  = state_r;
        end
      end
      S_LEN_LO: begin
        if (xfer_s) begin
          state_nx_s = S_LEN_HI;
        end else begin
          state_nx_s = state_r;
        end
      end
      S_LEN_HI: begin
        if (!xfer_s) begin
          state_nx_s = state_r;
        end else if (len_nx_s > 16'(MAX_WORDS)) begin
          state_nx_s = S_ERROR;
        end else if (len_nx_s == 16'd0) begin
          state_nx_s = S_CHECK;
        end else begin
          state_nx_s = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer_s && (byte_idx_r == 2'd3) && last_word_s) begin
          state_nx_s = S_CHECK;
        end else begin
          state_nx_s = state_r;
        end
      end
      S_CHECK: begin
        // Folding CHK into the running XOR yields zero exactly when they match.
        if (!xfer_s) begin
          state_nx_s = state_r;
        end else if (chk_nx_s == 8'd0) begin
          state_nx_s = S_DONE;
        end else begin
          state_nx_s = S_ERROR;
        end
      end
      default: begin
        state_nx_s = S_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs; status flags follow the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_r          <= 16'd0;
      chk_r          <= 8'd0;
      byte_idx_r     <= 2'd0;
      word_r         <= 32'd0;
      in_ready_r     <= 1'b0;
      wr_en_r        <= 1'b0;
      wr_addr_r      <= {ADDR_W{1'b0}};
      wr_data_r      <= 32'd0;
      core_rst_r     <= 1'b1;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      error_r        <= 1'b0;
      words_loaded_r <= 16'd0;
    end else begin
      in_ready_r <= is_active(state_nx_s);
      busy_r     <= is_active(state_nx_s);
      done_r     <= (state_nx_s == S_DONE);
      error_r    <= (state_nx_s == S_ERROR);
      core_rst_r <= (state_nx_s != S_DONE);
      wr_en_r    <= 1'b0;
      if (start_acc_s) begin
        words_loaded_r <= 16'd0;
        chk_r          <= 8'd0;
        byte_idx_r     <= 2'd0;
      end else if (xfer_s) begin
        chk_r <= chk_nx_s;
        case (state_r)
          S_LEN_LO: len_r[7:0]  <= bus.in_data;
          S_LEN_HI: len_r[15:8] <= bus.in_data;
          S_DATA: begin
            word_r[{byte_idx_r, 3'b000} +: 8] <= bus.in_data;
            byte_idx_r <= byte_idx_r + 2'd1;
            if (byte_idx_r == 2'd3) begin
              wr_en_r        <= 1'b1;
              wr_addr_r      <= {words_loaded_r[ADDR_W-3:0], 2'b00};
              wr_data_r      <= {bus.in_data, word_r[23:0]};
              words_loaded_r <= words_loaded_r + 16'd1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.wr_en     = wr_en_r;
  assign bus.wr_addr   = wr_addr_r;
  assign bus.wr_data   = wr_data_r;
  assign core_rst      = core_rst_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign error         = error_r;
  assign words_loaded  = words_loaded_r;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: a stream-level model predicts writes and final flags,
// a monitor checks every write pulse against it, and literal values pin the nominal image.
module tb_imem_boot_loader;
  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 256;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus),
    .core_rst     (core_rst),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  wr_t  exp_q[$];
  wr_t  cap_q[$];
  wr_t  mon_w;
  logic exp_done;
  logic exp_error;
  logic [15:0] exp_words;

  logic [7:0] nom_q[$];
  logic [7:0] bad_q[$];
  logic [7:0] big_q[$];
  logic [7:0] empty_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Stream-level model: decode length, slice payload into LE words, XOR-verify.
  task automatic model_stream(input logic [7:0] s[$]);
    int n;
    logic [7:0] x;
    wr_t w;
    n = int'({s[1], s[0]});
    if (n > MAX_WORDS) begin
      exp_done  = 1'b0;
      exp_error = 1'b1;
      exp_words = 16'd0;
    end else begin
      for (int k = 0; k < n; k++) begin
        w.addr = ADDR_W'(4 * k);
        w.data = {s[2+4*k+3], s[2+4*k+2], s[2+4*k+1], s[2+4*k]};
        exp_q.push_back(w);
      end
      x = 8'd0;
      for (int k = 0; k < 2 + 4 * n; k++) x = x ^ s[k];
      exp_done  = (x == s[2+4*n]);
      exp_error = !exp_done;
      exp_words = 16'(n);
    end
  endtask

  // Write monitor: every wr_en cycle must match the next predicted write.
  always @(negedge clk) begin
    if (mon_en && (bus.wr_en === 1'b1)) begin
      cap_q.push_back({bus.wr_addr, bus.wr_data});
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_wr: got addr %h data %h, expected no write", bus.wr_addr, bus.wr_data);
      end else begin
        mon_w = exp_q.pop_front();
        chk("wr_addr", 32'(bus.wr_addr), 32'(mon_w.addr));
        chk("wr_data", bus.wr_data, mon_w.data);
      end
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] s[$], input int count, input bit gaps);
    bit ok;
    for (int i = 0; i < count; i++) begin
      if (gaps) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'hA5;
        repeat (((i * 3) % 5) + 1) begin
          @(posedge clk); #1;
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = s[i];
      ok = 1'b0;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (bus.in_ready === 1'b1) begin
          @(posedge clk); #1;
          ok = 1'b1;
          break;
        end
        @(posedge clk); #1;
      end
      if (!ok) begin
        n_cmp++;
        n_fail++;
        $display("FAIL in_ready_timeout: got no ready for byte %0d, expected ready within 50 cycles", i);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic check_final(input string tag);
    chk({tag, "_done"},     32'(done),         32'(exp_done));
    chk({tag, "_error"},    32'(error),        32'(exp_error));
    chk({tag, "_core_rst"}, 32'(core_rst),     32'(!exp_done));
    chk({tag, "_words"},    32'(words_loaded), 32'(exp_words));
    chk({tag, "_busy"},     32'(busy),         32'd0);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_pending"},  32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_load(input string tag, input logic [7:0] s[$], input bit gaps);
    cap_q.delete();
    model_stream(s);
    do_start();
    send_bytes(s, s.size(), gaps);
    check_final(tag);
  endtask

  initial begin
    nom_q   = '{8'h03, 8'h00, 8'hB3, 8'h01, 8'h11, 8'h00, 8'h13, 8'h82, 8'h40, 8'h83,
                8'h03, 8'h25, 8'h81, 8'h3E, 8'h6B};
    bad_q   = nom_q;
    bad_q[bad_q.size()-1] = 8'h6A;
    big_q   = '{8'h01, 8'h01};
    empty_q = '{8'h00, 8'h00, 8'h00};

    rst = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_wr_en",    32'(bus.wr_en),    32'd0);
    chk("rst_wr_addr",  32'(bus.wr_addr),  32'd0);
    chk("rst_wr_data",  bus.wr_data,       32'd0);
    chk("rst_core_rst", 32'(core_rst),     32'd1);
    chk("rst_busy",     32'(busy),         32'd0);
    chk("rst_done",     32'(done),         32'd0);
    chk("rst_error",    32'(error),        32'd0);
    chk("rst_words",    32'(words_loaded), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Nominal load, plus literal pins on the captured writes.
    run_load("nominal", nom_q, 1'b0);
    chk("nom_done_lit",  32'(done),         32'd1);
    chk("nom_words_lit", 32'(words_loaded), 32'd3);
    chk("nom_nwr",       32'(cap_q.size()), 32'd3);
    if (cap_q.size() == 3) begin
      chk("nom_w0_data", cap_q[0].data,     32'h001101B3);
      chk("nom_w1_addr", 32'(cap_q[1].addr), 32'h004);
      chk("nom_w1_data", cap_q[1].data,     32'h83408213);
      chk("nom_w2_addr", 32'(cap_q[2].addr), 32'h008);
      chk("nom_w2_data", cap_q[2].data,     32'h3E812503);
    end

    // Restart from DONE: flags react the cycle after start.
    cap_q.delete();
    model_stream(nom_q);
    do_start();
    chk("restart_done",     32'(done),     32'd0);
    chk("restart_core_rst", 32'(core_rst), 32'd1);
    chk("restart_busy",     32'(busy),     32'd1);
    send_bytes(nom_q, nom_q.size(), 1'b0);
    check_final("restart");

    run_load("badchk", bad_q, 1'b0);
    chk("bad_error_lit", 32'(error), 32'd1);
    chk("bad_nwr",       32'(cap_q.size()), 32'd3);

    run_load("oversize", big_q, 1'b0);
    chk("big_error_lit", 32'(error), 32'd1);
    chk("big_nwr",       32'(cap_q.size()), 32'd0);

    run_load("empty", empty_q, 1'b0);
    chk("empty_core_rst_lit", 32'(core_rst), 32'd0);
    chk("empty_nwr",          32'(cap_q.size()), 32'd0);

    run_load("gaps", nom_q, 1'b1);
    chk("gaps_nwr", 32'(cap_q.size()), 32'd3);

    // Reset after 6 bytes: the word completed by byte 6 is written, then everything clears.
    cap_q.delete();
    exp_q.push_back('{addr: ADDR_W'(0), data: 32'h001101B3});
    do_start();
    send_bytes(nom_q, 6, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy",     32'(busy),         32'd0);
    chk("midrst_words",    32'(words_loaded), 32'd0);
    chk("midrst_core_rst", 32'(core_rst),     32'd1);
    chk("midrst_wr_en",    32'(bus.wr_en),    32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("midrst_pending",  32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    chk("midrst_wr_en2",   32'(bus.wr_en),    32'd0);
    run_load("after_rst", nom_q, 1'b0);
    chk("after_rst_nwr", 32'(cap_q.size()), 32'd3);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
